mem_access_unit: RTL and testbench

Load/store initiator that sits between the MIPS execute stage and the 32-bit byte-addressed RAM. It turns byte, halfword and word load/store requests into RAM word transactions. Because the RAM writes whole words, sub-word stores are done as read-modify-write. The block also handles the RAM's one-cycle registered read, sign/zero extension, range errors and alignment errors. Data is little-endian: byte lane `k` of the word at aligned address `A` is address `A+k`.

---
 rtl/mau_pkg.sv | 23 ++
 rtl/mem_lane_align.sv | 43 ++++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/mau_pkg.sv
// Shared types and lane-width constants for the MIPS load/store access unit.
package mau_pkg;

  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10,
    RSVD = 2'b11
  } mau_size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    CAPTURE,
    WRITE,
    RESP
  } mau_state_e;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned HALF_W = 16;
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane logic: extracts and extends a load lane, or merges store
// bytes into a captured RAM word (little-endian byte lanes).
module mem_lane_align
  import mau_pkg::*;
(
  input  mau_size_e         size,
  input  logic              is_unsigned,
  input  logic [1:0]        addr_lo,
  input  logic [WORD_W-1:0] word_in,
  input  logic [WORD_W-1:0] store_data,
  output logic [WORD_W-1:0] load_data,
  output logic [WORD_W-1:0] merged_word
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;
  logic              byte_sign;
  logic              half_sign;

  always_comb begin
    byte_lane = word_in[{addr_lo, 3'b000} +: BYTE_W];
    half_lane = word_in[{addr_lo[1], 4'b0000} +: HALF_W];
    byte_sign = byte_lane[BYTE_W-1] & ~is_unsigned;
    half_sign = half_lane[HALF_W-1] & ~is_unsigned;

    case (size)
      BYTE:    load_data = {{(WORD_W-BYTE_W){byte_sign}}, byte_lane};
      HALF:    load_data = {{(WORD_W-HALF_W){half_sign}}, half_lane};
      default: load_data = word_in;
    endcase
  end

  // Half lanes use addr[1] only, so an odd half address still lands on a half boundary.
  always_comb begin
    merged_word = word_in;
    case (size)
      BYTE:    merged_word[{addr_lo, 3'b000} +: BYTE_W]     = store_data[BYTE_W-1:0];
      HALF:    merged_word[{addr_lo[1], 4'b0000} +: HALF_W] = store_data[HALF_W-1:0];
      default: merged_word = store_data;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the execute stage and a word-wide registered RAM.
// Define MAU_MISALIGN_TRAP_EN to turn misaligned half/word accesses into errors.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [32:0] MEM_LIMIT = 33'(MEM_BYTES);

  mau_state_e  state_q, state_d;
  logic        we_q, we_d;
  mau_size_e   size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lo_q, lo_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  mau_size_e   req_size_e;
  logic [31:0] req_wa;
  logic        req_err;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_size_e = mau_size_e'(req_size);
  assign req_wa     = {req_addr[31:2], 2'b00};

  // Range check is done in 33 bits so addresses near 2^32 cannot wrap into range.
  always_comb begin
    req_err = 1'b0;
    if (req_size_e == RSVD) begin
      req_err = 1'b1;
`ifdef MAU_MISALIGN_TRAP_EN
    end else if ((req_size_e == HALF && req_addr[0]) ||
                 (req_size_e == WORD && req_addr[1:0] != 2'b00)) begin
      req_err = 1'b1;
`endif
    end else if ({1'b0, req_wa} + 33'd3 >= MEM_LIMIT) begin
      req_err = 1'b1;
    end
  end

  mem_lane_align u_lane (
    .size        (size_q),
    .is_unsigned (uns_q),
    .addr_lo     (lo_q),
    .word_in     (mem_rdata),
    .store_data  (wdata_q),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_comb begin
    // NOTE: every _d is defaulted first so no path through the case infers a latch.
    state_d     = state_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    lo_d        = lo_q;
    wdata_d     = wdata_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          size_d  = req_size_e;
          uns_d   = req_unsigned;
          lo_d    = req_addr[1:0];
          wdata_d = req_wdata;
          if (req_err) begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end else if (req_we && req_size_e == WORD) begin
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = req_wa;
            mem_wdata_d = req_wdata;
          end else begin
            state_d    = READ;
            mem_addr_d = req_wa;
          end
        end
      end
      READ: state_d = CAPTURE;
      CAPTURE: begin
        // mem_addr already holds the word address, so the write-back reuses it.
        if (we_q) begin
          state_d     = WRITE;
          mem_we_d    = 1'b1;
          mem_wdata_d = merged_word;
        end else begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = load_data;
        end
      end
      WRITE: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_rdata_d = '0;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      size_q      <= BYTE;
      uns_q       <= 1'b0;
      lo_q        <= 2'b00;
      wdata_q     <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q     <= state_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      lo_q        <= lo_d;
      wdata_q     <= wdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed, table-driven bench for mem_access_unit against a 16-byte registered RAM model.
module tb_mem_access_unit;

  localparam int MEM_BYTES = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  // Word RAM with one-cycle registered read, 4 words deep.
  logic [31:0] ram [4] = '{default: 32'h0};
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[3:2]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[3:2]];
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          we_cycles;
    logic [31:0] mem_word;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int          lat;
    int          we_cycles;
    logic [31:0] got_rdata;
    logic        got_err;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    logic [31:0] addr0;
    logic        addr_moved;
    @(negedge clk);
    check({v.name, " ready"}, {31'd0, req_ready}, 32'd1);
    check({v.name, " idle rsp"}, {31'd0, rsp_valid}, 32'd0);
    addr0        = mem_addr;
    // NOTE: bench drives use blocking assignments away from the active edge.
    req_valid    = 1'b1;
    req_we       = v.we;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_addr     = v.addr;
    req_wdata    = v.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; we_cycles = 0; addr_moved = 1'b0;
    got_rdata = '0; got_err = 1'b0; we_addr = '0; we_data = '0;
    for (int n = 1; n <= 8 && lat == 0; n++) begin
      @(negedge clk);
      if (mem_addr !== addr0) addr_moved = 1'b1;
      if (mem_we) begin
        we_cycles++;
        we_addr = mem_addr;
        we_data = mem_wdata;
      end
      if (rsp_valid) begin
        lat       = n;
        got_rdata = rsp_rdata;
        got_err   = rsp_err;
      end
    end
    check({v.name, " latency"}, 32'(lat), 32'(v.lat));
    check({v.name, " rdata"}, got_rdata, v.rdata);
    check({v.name, " err"}, {31'd0, got_err}, {31'd0, v.err});
    check({v.name, " we cycles"}, 32'(we_cycles), 32'(v.we_cycles));
    if (v.we && !v.err) begin
      check({v.name, " we addr"}, we_addr, {v.addr[31:2], 2'b00});
      check({v.name, " we data"}, we_data, v.mem_word);
    end
    if (v.err) check({v.name, " no access"}, {31'd0, addr_moved}, 32'd0);
  endtask

  initial begin
    vec_t v;
    logic seen_rsp;

    //                name          we    size  uns   addr          wdata         lat rdata         err  wec word
    vecs.push_back('{"sw @4",       1'b1, 2'd2, 1'b0, 32'h4,        32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 32'hDEADBEEF});
    vecs.push_back('{"lw @4",       1'b0, 2'd2, 1'b0, 32'h4,        32'h0,        3, 32'hDEADBEEF, 1'b0, 0, 32'h0});
    vecs.push_back('{"sw @8",       1'b1, 2'd2, 1'b0, 32'h8,        32'h11223344, 2, 32'h0,        1'b0, 1, 32'h11223344});
    vecs.push_back('{"sb @9",       1'b1, 2'd0, 1'b0, 32'h9,        32'h123456AB, 4, 32'h0,        1'b0, 1, 32'h1122AB44});
    vecs.push_back('{"lb @9",       1'b0, 2'd0, 1'b0, 32'h9,        32'h0,        3, 32'hFFFFFFAB, 1'b0, 0, 32'h0});
    vecs.push_back('{"lbu @9",      1'b0, 2'd0, 1'b1, 32'h9,        32'h0,        3, 32'h000000AB, 1'b0, 0, 32'h0});
    vecs.push_back('{"lw @8 a",     1'b0, 2'd2, 1'b0, 32'h8,        32'h0,        3, 32'h1122AB44, 1'b0, 0, 32'h0});
    vecs.push_back('{"sh @A",       1'b1, 2'd1, 1'b0, 32'hA,        32'hFFFF8001, 4, 32'h0,        1'b0, 1, 32'h8001AB44});
    vecs.push_back('{"lh @A",       1'b0, 2'd1, 1'b0, 32'hA,        32'h0,        3, 32'hFFFF8001, 1'b0, 0, 32'h0});
    vecs.push_back('{"lhu @A",      1'b0, 2'd1, 1'b1, 32'hA,        32'h0,        3, 32'h00008001, 1'b0, 0, 32'h0});
    vecs.push_back('{"lw @8 b",     1'b0, 2'd2, 1'b0, 32'h8,        32'h0,        3, 32'h8001AB44, 1'b0, 0, 32'h0});
    vecs.push_back('{"lw @10",      1'b0, 2'd2, 1'b0, 32'h10,       32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{"sw @10",      1'b1, 2'd2, 1'b0, 32'h10,       32'h55,       1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{"lw @FFFFFFFC",1'b0, 2'd2, 1'b0, 32'hFFFFFFFC, 32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{"rsvd size",   1'b0, 2'd3, 1'b0, 32'h0,        32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{"sw @C",       1'b1, 2'd2, 1'b0, 32'hC,        32'hCAFEF00D, 2, 32'h0,        1'b0, 1, 32'hCAFEF00D});
    vecs.push_back('{"lb @F",       1'b0, 2'd0, 1'b0, 32'hF,        32'h0,        3, 32'hFFFFFFCA, 1'b0, 0, 32'h0});
    vecs.push_back('{"lbu @E",      1'b0, 2'd0, 1'b1, 32'hE,        32'h0,        3, 32'h000000FE, 1'b0, 0, 32'h0});
    vecs.push_back('{"lhu @C",      1'b0, 2'd1, 1'b1, 32'hC,        32'h0,        3, 32'h0000F00D, 1'b0, 0, 32'h0});
    vecs.push_back('{"lh @C",       1'b0, 2'd1, 1'b0, 32'hC,        32'h0,        3, 32'hFFFFF00D, 1'b0, 0, 32'h0});
    vecs.push_back('{"sb @C",       1'b1, 2'd0, 1'b0, 32'hC,        32'hFFFFFF5A, 4, 32'h0,        1'b0, 1, 32'hCAFEF05A});
    vecs.push_back('{"lw @C",       1'b0, 2'd2, 1'b0, 32'hC,        32'h0,        3, 32'hCAFEF05A, 1'b0, 0, 32'h0});
`ifdef MAU_MISALIGN_TRAP_EN
    vecs.push_back('{"lw @6",       1'b0, 2'd2, 1'b0, 32'h6,        32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{"lh @7",       1'b0, 2'd1, 1'b0, 32'h7,        32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
    vecs.push_back('{"lhu @5",      1'b0, 2'd1, 1'b1, 32'h5,        32'h0,        1, 32'h0,        1'b1, 0, 32'h0});
`else
    vecs.push_back('{"lw @6",       1'b0, 2'd2, 1'b0, 32'h6,        32'h0,        3, 32'hDEADBEEF, 1'b0, 0, 32'h0});
    vecs.push_back('{"lh @7",       1'b0, 2'd1, 1'b0, 32'h7,        32'h0,        3, 32'hFFFFDEAD, 1'b0, 0, 32'h0});
    vecs.push_back('{"lhu @5",      1'b0, 2'd1, 1'b1, 32'h5,        32'h0,        3, 32'h0000BEEF, 1'b0, 0, 32'h0});
`endif

    // Reset state, checked while reset is held.
    #12;
    check("reset req_ready", {31'd0, req_ready}, 32'd1);
    check("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset rsp_rdata", rsp_rdata, 32'h0);
    check("reset rsp_err", {31'd0, rsp_err}, 32'd0);
    check("reset mem_we", {31'd0, mem_we}, 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset mem_wdata", mem_wdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // sb @8 interrupted by reset during its WRITE cycle.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h8; req_wdata = 32'h00000077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst write active", {31'd0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check("rst async we drop", {31'd0, mem_we}, 32'd0);
    check("rst async rsp", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen_rsp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp = 1'b1;
    end
    check("rst no rsp", {31'd0, seen_rsp}, 32'd0);
    check("rst req_ready", {31'd0, req_ready}, 32'd1);
    check("rst mem_addr", mem_addr, 32'h0);
    check("rst ram unchanged", ram[2], 32'h8001AB44);

    v = '{"lw @8 after rst", 1'b0, 2'd2, 1'b0, 32'h8, 32'h0, 3, 32'h8001AB44, 1'b0, 0, 32'h0};
    run_vec(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
